// File: rtl/jamma_input_scan_if.sv
// JAMMA-side and core-side signal bundle for jamma_input_scan.
// slave is the scanner's view; master is the edge-connector/core side.
interface jamma_input_scan_if;
  logic [7:0] JJOY;
  logic [1:0] JCOIN;
  logic [5:0] JOYSTICK;
  logic       JSELECT;
  logic [7:0] joystick1;
  logic [7:0] joystick2;
  logic [1:0] coin;
  logic       scan_valid;

  modport master (
    output JJOY, JCOIN, JOYSTICK,
    input  JSELECT, joystick1, joystick2, coin, scan_valid
  );

  modport slave (
    input  JJOY, JCOIN, JOYSTICK,
    output JSELECT, joystick1, joystick2, coin, scan_valid
  );
endinterface

// File: rtl/jamma_input_scan.sv
// Paced JAMMA joystick mux scan with 2-flop synchronisers and per-bit debounce.
// Outputs are active low and change only in the cycle after a sample state.
module jamma_input_scan #(
  parameter int unsigned SETTLE   = 3,
  parameter int unsigned DEBOUNCE = 4
) (
  input logic               pclk,
  input logic               reset,
  jamma_input_scan_if.slave bus
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [2:0] DB_LAST     = 3'(DEBOUNCE - 1);

  typedef enum logic [1:0] {
    P1_SETTLE,
    P1_SAMPLE,
    P2_SETTLE,
    P2_SAMPLE
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       sel_d, sel_q;
  logic       p1_stb, p2_stb;
  logic       scan_valid_q;

  logic [7:0] jjoy_s1, jjoy_s2;
  logic [1:0] jcoin_s1, jcoin_s2;
  logic [5:0] joy_s1, joy_s2;

  // Debounced bits flattened as {coin[1:0], joystick2[7:0], joystick1[7:0]}.
  logic [17:0] out_q;
  logic [17:0] samp;
  logic [17:0] stb;
  logic [2:0]  db_cnt [18];

  always_ff @(posedge pclk) begin
    if (reset) begin
      jjoy_s1  <= '1;
      jjoy_s2  <= '1;
      jcoin_s1 <= '1;
      jcoin_s2 <= '1;
      joy_s1   <= '1;
      joy_s2   <= '1;
    end else begin
      jjoy_s1  <= bus.JJOY;
      jjoy_s2  <= jjoy_s1;
      jcoin_s1 <= bus.JCOIN;
      jcoin_s2 <= jcoin_s1;
      joy_s1   <= bus.JOYSTICK;
      joy_s2   <= joy_s1;
    end
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      state_q      <= P1_SETTLE;
      cnt_q        <= '0;
      sel_q        <= 1'b0;
      scan_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sel_q        <= sel_d;
      scan_valid_q <= p2_stb;
    end
  end

  // JSELECT is registered from the next state so the mux line never glitches.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p1_stb  = 1'b0;
    p2_stb  = 1'b0;
    unique case (state_q)
      P1_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = P1_SAMPLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      P1_SAMPLE: begin
        p1_stb  = 1'b1;
        state_d = P2_SETTLE;
        cnt_d   = '0;
      end
      P2_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = P2_SAMPLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      P2_SAMPLE: begin
        p2_stb  = 1'b1;
        state_d = P1_SETTLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = P1_SETTLE;
        cnt_d   = '0;
      end
    endcase
    sel_d = (state_d == P2_SETTLE) || (state_d == P2_SAMPLE);
  end

  always_comb begin
    samp = {jcoin_s2, jjoy_s2, jjoy_s2 & {2'b11, joy_s2}};
    stb  = {{10{p2_stb}}, {8{p1_stb}}};
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      out_q <= '1;
      for (int unsigned i = 0; i < 18; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 18; i++) begin
        if (stb[i]) begin
          if (samp[i] == out_q[i]) begin
            db_cnt[i] <= '0;
          end else if (db_cnt[i] == DB_LAST) begin
            out_q[i]  <= samp[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 3'd1;
          end
        end
      end
    end
  end

  assign bus.JSELECT    = sel_q;
  assign bus.joystick1  = out_q[7:0];
  assign bus.joystick2  = out_q[15:8];
  assign bus.coin       = out_q[17:16];
  assign bus.scan_valid = scan_valid_q;

endmodule

// File: doc/jamma_input_scan.md
# jamma_input_scan

Upstream input stage between the JAMMA edge connector and the arcade core wrapper. It drives the JAMMA joystick multiplexer select line, lets the bus settle, and samples the shared 8-bit JJOY bus once per player. It synchronises and debounces every joystick and coin bit and delivers clean, active-low player buses and coin lines to the core. It replaces the free-running per-clock select toggle with a paced, glitch-filtered scan.

## Interface
Parameters:
- SETTLE, 3: cycles JSELECT is held before each sample; legal range 3..15, must cover the 2-flop synchroniser latency.
- DEBOUNCE, 4: consecutive identical samples needed to change an output bit; legal range 1..7.

Ports:
- pclk  in  1  core pixel clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- JJOY  in  8  multiplexed JAMMA bus, active low: [5:0] directions/buttons, [7] start.
- JCOIN  in  2  coin switches, active low, [0]=P1, [1]=P2.
- JOYSTICK  in  6  local DB9 joystick, active low, merged into player 1.
- JSELECT  out  1  mux select: 0 selects player 1, 1 selects player 2.
- joystick1  out  8  debounced player 1 bus, active low.
- joystick2  out  8  debounced player 2 bus, active low.
- coin  out  2  debounced coins, active low.
- scan_valid  out  1  one-cycle strobe, high when a full P1+P2 scan has been applied to the outputs.

## Operation
- Synchroniser: JJOY, JCOIN and JOYSTICK each pass through two flops. The flops reset to all ones (idle).
- FSM states are P1_SETTLE, P1_SAMPLE, P2_SETTLE and P2_SAMPLE, with a 4-bit settle counter.
  - P1_SETTLE: JSELECT=0. The counter runs 0..SETTLE-1, then the FSM moves to P1_SAMPLE.
  - P1_SAMPLE: JSELECT=0, one cycle. It captures p1_raw = sync(JJOY) & {2'b11, sync(JOYSTICK)}. The FSM then moves to P2_SETTLE and clears the counter.
  - P2_SETTLE: JSELECT=1. It behaves like P1_SETTLE.
  - P2_SAMPLE: JSELECT=1, one cycle. It captures p2_raw = sync(JJOY) and coin_raw = sync(JCOIN), then returns to P1_SETTLE.
  - Scan period is 2*(SETTLE+1) cycles, which is 8 at the defaults.
- Debounce: each of the 18 output bits has its own 3-bit counter, advanced only on that bit's sample strobe.
  - If the sample equals the current output, the counter clears.
  - Otherwise the counter increments. When it reaches DEBOUNCE, the output bit takes the sampled value and the counter clears.
  - Coin bits use the P2_SAMPLE strobe.
- With DEBOUNCE=1, every sample that differs from the output is applied immediately.
- The outputs are registered. They change only in the cycle after a sample state.
- scan_valid is high for exactly the cycle after P2_SAMPLE, every scan, whether or not any bit changed.

## Timing
- Reset values:
  - JSELECT=0, joystick1=8'hFF, joystick2=8'hFF, coin=2'b11, scan_valid=0.
  - FSM in P1_SETTLE with counter=0; all debounce counters=0; synchroniser flops=1.
- Reset mid-scan: on the next pclk edge with reset=1, all reset values apply regardless of state. After reset deasserts, the first P1_SAMPLE occurs SETTLE cycles later.
- Select-to-sample: data is captured SETTLE cycles after the edge that changed JSELECT. External bus settling plus the synchroniser must fit in that window.
- Change latency at defaults: a held input change is applied 1 cycle after the 4th matching sample of its player, i.e. within 4 scans (32 cycles) plus synchroniser delay.
- A glitch that spans fewer than DEBOUNCE consecutive samples never reaches the outputs. An interrupted run restarts counting from 0.
- Simultaneous events: each bit is debounced independently. Multiple bits may change in the same cycle; P1 bits and P2 bits update in different cycles.
- When JJOY changes during a settle window, only the value present at the sample point counts.

## Test plan
- Reset check: hold reset 3 cycles, then release. Required: JSELECT=0 and the outputs at 8'hFF / 8'hFF / 2'b11 throughout reset. Defaults give JSELECT 0,0,0,0,1,1,1,1 repeating, and scan_valid pulses every 8 cycles.
- Player 1 press: drive JJOY=8'hFE only while JSELECT=0, hold it, and drive 8'hFF otherwise. Required: joystick1=8'hFE 1 cycle after the 4th P1_SAMPLE; joystick2 stays 8'hFF.
- Glitch rejection: pull P2 bit 7 low for 3 consecutive P2 samples, then release. Required: joystick2 stays 8'hFF. Then hold it low for 4 samples. Required: joystick2=8'h7F.
- Local merge: JJOY=8'hFF and JOYSTICK=6'b111101. Required: joystick1=8'hFD after 4 scans; joystick2=8'hFF.
- Coin and reset interaction: JCOIN=2'b10 for 4 scans. Required: coin=2'b10. Then assert reset in P2_SETTLE. Required: the next cycle gives coin=2'b11, JSELECT=0 and counters cleared; after release, 4 further scans are needed to return to 2'b10.
